// File: rtl/simple_pkg.sv
// Shared constants, instruction field layout and decode helpers for the SIMPLE datapath.
package simple_pkg;

  localparam int DATA_W  = 16;
  localparam int NREG    = 8;
  localparam int REG_W   = $clog2(NREG);
  localparam int INSTR_W = 16;

  localparam int CLS_LSB = 14;
  localparam int RS_LSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int OP_LSB  = 4;
  localparam int D_LSB   = 0;

  localparam logic [1:0] CLS_ARITH = 2'b11;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h8;
  localparam logic [3:0] OP_SLR = 4'h9;
  localparam logic [3:0] OP_SRL = 4'hA;
  localparam logic [3:0] OP_SRA = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        salu;
    logic [REG_W-1:0]  rd;
    logic              wr;
  } alu_req_t;

  function automatic logic is_shift(input logic [3:0] op3);
    return op3 inside {OP_SLL, OP_SLR, OP_SRL, OP_SRA};
  endfunction

  function automatic logic is_legal(input logic [1:0] cls, input logic [3:0] op3);
    logic ok;
    case (op3)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_MOV,
      OP_SLL, OP_SLR, OP_SRL, OP_SRA, OP_HLT: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return (cls == CLS_ARITH) && ok;
  endfunction

endpackage

// File: rtl/simple_regfile.sv
// NREG x DATA_W register file: two async read ports with write-through bypass, one write port.
// Zero-latency reads; a same-cycle write to the read address is forwarded.
module simple_regfile
  import simple_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_W-1:0]  ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [REG_W-1:0]  rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o
);

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = (we_i && (waddr_i == ra_addr_i)) ? wdata_i : mem_q[ra_addr_i];
  assign rb_data_o = (we_i && (waddr_i == rb_addr_i)) ? wdata_i : mem_q[rb_addr_i];

endmodule

// File: rtl/simple_operand_stage.sv
// Issue stage ahead of the ALU: decode, operand read, RAW/WAW scoreboard, registered valid/ready output.
// One cycle accept-to-out_valid; input stalls on hazards, halt, or a held output.
module simple_operand_stage
  import simple_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [3:0]         out_salu,
  output logic [REG_W-1:0]   out_rd,
  output logic               out_wr,
  input  logic               wb_en,
  input  logic [REG_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               illegal,
  output logic               halted
);

  logic [1:0]       cls;
  logic [REG_W-1:0] rs, rd;
  logic [3:0]       op3, dfield;

  assign cls    = in_instr[CLS_LSB +: 2];
  assign rs     = in_instr[RS_LSB +: REG_W];
  assign rd     = in_instr[RD_LSB +: REG_W];
  assign op3    = in_instr[OP_LSB +: 4];
  assign dfield = in_instr[D_LSB +: 4];

  logic legal, hlt, op_vld, shift, reads_rd, reads_rs, wr;

  // HLT and illegal words never touch registers, so they cannot stall on hazards.
  assign legal    = is_legal(cls, op3);
  assign hlt      = legal && (op3 == OP_HLT);
  assign op_vld   = legal && !hlt;
  assign shift    = is_shift(op3);
  assign reads_rd = op_vld && (op3 != OP_MOV);
  assign reads_rs = op_vld && !shift;
  assign wr       = op_vld && (op3 != OP_CMP);

  logic [DATA_W-1:0] rd_data, rs_data;

  simple_regfile u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .ra_addr_i (rd),
    .ra_data_o (rd_data),
    .rb_addr_i (rs),
    .rb_data_o (rs_data)
  );

  logic [NREG-1:0] pend_q, pend_d;
  logic            out_vld_q, illegal_q, halted_q;
  alu_req_t        out_q, out_d;
  logic            rs_byp, rd_byp, hazard, accept;

  assign rs_byp = wb_en && (wb_addr == rs);
  assign rd_byp = wb_en && (wb_addr == rd);
  assign hazard = (pend_q[rs] && reads_rs && !rs_byp) ||
                  (pend_q[rd] && (reads_rd || wr) && !rd_byp);

  assign in_ready = !halted_q && !rst && (!out_vld_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_d.a    = rd_data;
    out_d.b    = shift ? {{(DATA_W-4){1'b0}}, dfield} : rs_data;
    out_d.salu = op3;
    out_d.rd   = rd;
    out_d.wr   = wr;
  end

  // Set after clear so a same-cycle issue to the written register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wb_en)         pend_d[wb_addr] = 1'b0;
    if (accept && wr)  pend_d[rd]      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      pend_q    <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      illegal_q <= accept && !legal;
      if (accept && hlt) halted_q <= 1'b1;
      if (accept && op_vld) begin
        out_vld_q <= 1'b1;
        out_q     <= out_d;
      end else if (out_ready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_a     = out_q.a;
  assign out_b     = out_q.b;
  assign out_salu  = out_q.salu;
  assign out_rd    = out_q.rd;
  assign out_wr    = out_q.wr;
  assign illegal   = illegal_q;
  assign halted    = halted_q;

endmodule
